// File: rtl/fft_reorder_pkg.sv
// Shared definitions for the FFT output reorder buffer: default sizes and the
// writer/reader state encodings.
package fft_reorder_pkg;

    localparam int DEFAULT_WIDTH      = 18;    // sample component width
    localparam int DEFAULT_ADDR_W     = 11;    // address / index width
    localparam int DEFAULT_MAX_POINTS = 1200;  // bank depth, largest transform

    typedef enum logic {
        W_IDLE,
        W_FILL
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_PRIME,
        R_STREAM
    } rd_state_t;

endpackage

// File: rtl/reorder_bank.sv
// One frame bank: simple dual-port RAM with one write port and one
// synchronous read port (1-cycle latency). The read register only updates on
// re, so it doubles as the stall-holding output register of the reorder block.
import fft_reorder_pkg::*;

module reorder_bank #(
    parameter int DATA_W = 2 * DEFAULT_WIDTH,
    parameter int DEPTH  = DEFAULT_MAX_POINTS,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port: store the incoming sample at its natural-order address.
    // NOTE: the storage array is deliberately left out of reset so it maps onto
    // block RAM; sequential state uses non-blocking assignments throughout.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: registered read, held while re is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fft_out_reorder.sv
// Output-side reorder buffer for the mixed-radix FFT. Scrambled-order samples
// are written into one of two banks by target address; a completed bank is
// streamed out in natural index order over valid/ready while the other fills.
// Optional build macro FFT_OUT_CONJ_EN: out_im is the saturating negation of
// the stored imaginary part (conjugated output for IDFT use).
import fft_reorder_pkg::*;

module fft_out_reorder #(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int ADDR_W     = DEFAULT_ADDR_W,
    parameter int MAX_POINTS = DEFAULT_MAX_POINTS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] points,
    input  logic [WIDTH-1:0]  in_re,
    input  logic [WIDTH-1:0]  in_im,
    input  logic              in_en,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              in_finish,
    output logic [WIDTH-1:0]  out_re,
    output logic [WIDTH-1:0]  out_im,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last,
    output logic              ovf_err,
    output logic              addr_err
);

    // Bank bookkeeping shared between writer and reader.
    logic [1:0]        full;
    logic [ADDR_W-1:0] size_q [2];
    logic              wbank;
    logic              rbank;

    wr_state_t         wstate;
    rd_state_t         rstate;

    // Writer decode.
    logic [ADDR_W-1:0] w_size;
    logic              w_take;
    logic              w_addr_ok;
    logic              w_we;
    logic              full_set;

    // Reader decode.
    logic [ADDR_W-1:0] r_size;
    logic [ADDR_W-1:0] next_index;
    logic              r_fire;
    logic              r_done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;

    // Bank data paths.
    logic [2*WIDTH-1:0] wdata;
    logic [2*WIDTH-1:0] rdata0;
    logic [2*WIDTH-1:0] rdata1;
    logic [2*WIDTH-1:0] rd_word;
    logic [WIDTH-1:0]   rd_im;

    // Writer decode: the frame size comes from the points port on the first
    // sample of a frame and from the latched size afterwards.
    // NOTE: every signal gets a default at the top so no latch is inferred.
    always_comb begin
        w_size    = size_q[wbank];
        w_take    = 1'b0;
        w_addr_ok = 1'b0;
        w_we      = 1'b0;
        full_set  = 1'b0;
        if (wstate == W_IDLE) begin
            w_size = points;
        end
        w_take    = in_en && !full[wbank];
        w_addr_ok = (in_addr < w_size);
        w_we      = w_take && w_addr_ok;
        full_set  = w_take && in_finish;
    end

    // Writer FSM: latch frame size, flag drops, close frames on in_finish.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate    <= W_IDLE;
            wbank     <= 1'b0;
            size_q[0] <= '0;
            size_q[1] <= '0;
            ovf_err   <= 1'b0;
            addr_err  <= 1'b0;
        end else if (in_en) begin
            if (full[wbank]) begin
                // No free bank: the sample and any finish strobe are lost.
                ovf_err <= 1'b1;
            end else begin
                if (wstate == W_IDLE) begin
                    size_q[wbank] <= points;
                end
                if (!w_addr_ok) begin
                    addr_err <= 1'b1;
                end
                if (in_finish) begin
                    wbank  <= ~wbank;
                    wstate <= W_IDLE;
                end else begin
                    wstate <= W_FILL;
                end
            end
        end
    end

    // Full flags: writer sets the bank it closes, reader clears the bank it
    // finished draining; the two always refer to different banks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 2'b00;
        end else begin
            if (full_set) begin
                full[wbank] <= 1'b1;
            end
            if (r_done) begin
                full[rbank] <= 1'b0;
            end
        end
    end

    // Reader decode: read index 0 when priming, prefetch the next index on
    // each accepted sample except the last of the frame.
    always_comb begin
        r_size     = size_q[rbank];
        next_index = out_index + ADDR_W'(1);
        r_fire     = (rstate == R_STREAM) && out_valid && out_ready;
        r_done     = r_fire && out_last;
        rd_en      = 1'b0;
        rd_addr    = next_index;
        if (rstate == R_PRIME) begin
            rd_en   = 1'b1;
            rd_addr = '0;
        end else if (r_fire && !out_last) begin
            rd_en   = 1'b1;
        end
    end

    // Reader FSM: prime, then stream the full bank in natural order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rstate    <= R_IDLE;
            rbank     <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_index <= '0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (full[rbank]) begin
                        rstate <= R_PRIME;
                    end
                end
                R_PRIME: begin
                    out_valid <= 1'b1;
                    out_index <= '0;
                    out_last  <= (r_size == ADDR_W'(1));
                    rstate    <= R_STREAM;
                end
                R_STREAM: begin
                    if (r_fire) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_index <= '0;
                            rbank     <= ~rbank;
                            rstate    <= R_IDLE;
                        end else begin
                            out_index <= next_index;
                            out_last  <= (next_index == r_size - ADDR_W'(1));
                        end
                    end
                end
                default: begin
                    rstate <= R_IDLE;
                end
            endcase
        end
    end

    assign wdata = {in_re, in_im};

    reorder_bank #(
        .DATA_W (2 * WIDTH),
        .DEPTH  (MAX_POINTS),
        .ADDR_W (ADDR_W)
    ) u_bank0 (
        .clk   (clk),
        .rst   (rst),
        .we    (w_we && (wbank == 1'b0)),
        .waddr (in_addr),
        .wdata (wdata),
        .re    (rd_en && (rbank == 1'b0)),
        .raddr (rd_addr),
        .rdata (rdata0)
    );

    reorder_bank #(
        .DATA_W (2 * WIDTH),
        .DEPTH  (MAX_POINTS),
        .ADDR_W (ADDR_W)
    ) u_bank1 (
        .clk   (clk),
        .rst   (rst),
        .we    (w_we && (wbank == 1'b1)),
        .waddr (in_addr),
        .wdata (wdata),
        .re    (rd_en && (rbank == 1'b1)),
        .raddr (rd_addr),
        .rdata (rdata1)
    );

    // The bank read register is the output register; select the active bank.
    assign rd_word = rbank ? rdata1 : rdata0;
    assign out_re  = rd_word[2*WIDTH-1:WIDTH];
    assign rd_im   = rd_word[WIDTH-1:0];

`ifdef FFT_OUT_CONJ_EN
    localparam logic [WIDTH-1:0] IM_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] IM_MAX = {1'b0, {(WIDTH-1){1'b1}}};

    // Saturating negation of the registered im; the most negative value maps
    // to the most positive one instead of wrapping.
    always_comb begin
        out_im = (~rd_im) + WIDTH'(1);
        if (rd_im == IM_MIN) begin
            out_im = IM_MAX;
        end
    end
`else
    assign out_im = rd_im;
`endif

endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed bench for fft_out_reorder: scrambled writes, natural-order drain,
// stalls, overflow and address drops, reset mid-frame, size-1 frames and the
// optional conjugate output.
import fft_reorder_pkg::*;

module tb_fft_out_reorder;

    localparam int W  = DEFAULT_WIDTH;
    localparam int AW = DEFAULT_ADDR_W;
    localparam int MP = DEFAULT_MAX_POINTS;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] points;
    logic [W-1:0]  in_re;
    logic [W-1:0]  in_im;
    logic          in_en;
    logic [AW-1:0] in_addr;
    logic          in_finish;
    logic [W-1:0]  out_re;
    logic [W-1:0]  out_im;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_index;
    logic          out_last;
    logic          ovf_err;
    logic          addr_err;

    int n_tests = 0;
    int n_fail  = 0;

    fft_out_reorder #(
        .WIDTH      (W),
        .ADDR_W     (AW),
        .MAX_POINTS (MP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .points    (points),
        .in_re     (in_re),
        .in_im     (in_im),
        .in_en     (in_en),
        .in_addr   (in_addr),
        .in_finish (in_finish),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_last  (out_last),
        .ovf_err   (ovf_err),
        .addr_err  (addr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sample content for frame f, natural index i.
    function automatic logic [W-1:0] exp_re(input int f, input int i);
        return W'(f * 4096 + i);
    endfunction

    function automatic logic [W-1:0] raw_im(input int f, input int i);
        return ~exp_re(f, i);
    endfunction

    // Expected out_im for a stored im value.
    function automatic logic [W-1:0] exp_out_im(input logic [W-1:0] v);
`ifdef FFT_OUT_CONJ_EN
        if (v == {1'b1, {(W-1){1'b0}}}) return {1'b0, {(W-1){1'b1}}};
        return (~v) + W'(1);
`else
        return v;
`endif
    endfunction

    // One input sample; called just after a falling edge, returns one cycle later.
    task automatic wr(input int a, input logic [W-1:0] re, input logic [W-1:0] im, input logic fin);
        in_en     = 1'b1;
        in_addr   = AW'(a);
        in_re     = re;
        in_im     = im;
        in_finish = fin;
        @(negedge clk);
        in_en     = 1'b0;
        in_finish = 1'b0;
    endtask

    // Whole frame with address order (k*step) mod pts; step coprime with pts.
    task automatic send_frame(input int f, input int pts, input int step);
        points = AW'(pts);
        for (int k = 0; k < pts; k++) begin
            int a;
            a = (k * step) % pts;
            wr(a, exp_re(f, a), raw_im(f, a), k == pts - 1);
        end
    endtask

    // Drain nfr frames of pts samples starting at frame f0. With toggle set,
    // out_ready alternates 1/0; otherwise it is held high and the idle gap
    // between frames is checked.
    task automatic collect(input int f0, input int nfr, input int pts, input bit toggle, input int budget);
        int k;
        int cyc;
        int gap;
        int total;
        int f;
        int idx;
        k     = 0;
        cyc   = 0;
        gap   = 0;
        total = nfr * pts;
        while (k < total && cyc < budget) begin
            out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            f   = f0 + k / pts;
            idx = k % pts;
            if (out_valid) begin
                check($sformatf("f%0d i%0d index", f, idx), 32'(out_index), 32'(idx));
                check($sformatf("f%0d i%0d re", f, idx), 32'(out_re), 32'(exp_re(f, idx)));
                check($sformatf("f%0d i%0d im", f, idx), 32'(out_im), 32'(exp_out_im(raw_im(f, idx))));
                if (out_ready) begin
                    check($sformatf("f%0d i%0d last", f, idx), 32'(out_last), 32'(idx == pts - 1));
                    if (!toggle && k > 0 && idx == 0) begin
                        check($sformatf("f%0d gap", f), 32'(gap), 32'd2);
                    end
                    k++;
                    gap = 0;
                end
            end else begin
                gap++;
            end
            @(negedge clk);
            cyc++;
        end
        check($sformatf("f%0d drained", f0), 32'(k), 32'(total));
        out_ready = 1'b1;
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_en     = 1'b0;
        in_finish = 1'b0;
        in_addr   = '0;
        in_re     = '0;
        in_im     = '0;
        points    = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_last", 32'(out_last), 32'd0);
        check("rst out_index", 32'(out_index), 32'd0);
        check("rst out_re", 32'(out_re), 32'd0);
        check("rst out_im", 32'(out_im), 32'd0);
        check("rst ovf_err", 32'(ovf_err), 32'd0);
        check("rst addr_err", 32'(addr_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 12-point frame in stride order, first out_valid two cycles after full.
        out_ready = 1'b1;
        points    = AW'(12);
        for (int k = 0; k < 12; k++) begin
            int a;
            a = (k % 3) * 4 + k / 3;
            wr(a, exp_re(1, a), raw_im(1, a), k == 11);
        end
        check("lat c1 out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat c2 out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat c3 out_valid", 32'(out_valid), 32'd1);
        collect(1, 1, 12, 1'b0, 40);

        // Two 60-point frames back to back against a 50% ready downstream.
        fork
            begin
                send_frame(2, 60, 7);
                send_frame(3, 60, 7);
            end
            collect(2, 2, 60, 1'b1, 600);
        join
        check("b2b ovf_err", 32'(ovf_err), 32'd0);

        // Three 8-point frames with no drain: the third one is dropped.
        out_ready = 1'b0;
        send_frame(4, 8, 3);
        send_frame(5, 8, 3);
        send_frame(6, 8, 3);
        check("ovf ovf_err", 32'(ovf_err), 32'd1);
        check("ovf addr_err", 32'(addr_err), 32'd0);
        collect(4, 2, 8, 1'b0, 100);
        repeat (5) @(negedge clk);
        check("ovf no third frame", 32'(out_valid), 32'd0);

        // 5-point frame with an out-of-range address injected.
        points = AW'(5);
        wr(2, exp_re(7, 2), raw_im(7, 2), 1'b0);
        wr(0, exp_re(7, 0), raw_im(7, 0), 1'b0);
        wr(7, exp_re(99, 7), raw_im(99, 7), 1'b0);
        wr(4, exp_re(7, 4), raw_im(7, 4), 1'b0);
        wr(1, exp_re(7, 1), raw_im(7, 1), 1'b0);
        wr(3, exp_re(7, 3), raw_im(7, 3), 1'b1);
        check("addr addr_err", 32'(addr_err), 32'd1);
        collect(7, 1, 5, 1'b0, 20);

        // Reset in the middle of a 1200-point frame, then a clean frame.
        points = AW'(MP);
        for (int k = 0; k < 600; k++) begin
            int a;
            a = (k * 7) % MP;
            wr(a, exp_re(8, a), raw_im(8, a), 1'b0);
        end
        rst = 1'b1;
        #1;
        check("mid rst out_valid", 32'(out_valid), 32'd0);
        check("mid rst out_last", 32'(out_last), 32'd0);
        check("mid rst out_index", 32'(out_index), 32'd0);
        check("mid rst out_re", 32'(out_re), 32'd0);
        check("mid rst out_im", 32'(out_im), 32'd0);
        check("mid rst ovf_err", 32'(ovf_err), 32'd0);
        check("mid rst addr_err", 32'(addr_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("post rst no output", 32'(out_valid), 32'd0);
        send_frame(9, MP, 7);
        collect(9, 1, MP, 1'b0, 1300);

        // Conjugate boundary: most negative im and a small positive im.
        points = AW'(2);
        wr(0, 18'h00010, 18'h20000, 1'b0);
        wr(1, 18'h00020, 18'h00005, 1'b1);
        repeat (2) @(negedge clk);
        check("conj valid", 32'(out_valid), 32'd1);
        check("conj re0", 32'(out_re), 32'h00010);
`ifdef FFT_OUT_CONJ_EN
        check("conj im0", 32'(out_im), 32'h1FFFF);
`else
        check("conj im0", 32'(out_im), 32'h20000);
`endif
        @(negedge clk);
        check("conj re1", 32'(out_re), 32'h00020);
`ifdef FFT_OUT_CONJ_EN
        check("conj im1", 32'(out_im), 32'h3FFFB);
`else
        check("conj im1", 32'(out_im), 32'h00005);
`endif
        check("conj last", 32'(out_last), 32'd1);
        @(negedge clk);
        check("conj done", 32'(out_valid), 32'd0);

        // Single-point frame.
        points = AW'(1);
        wr(0, exp_re(10, 0), raw_im(10, 0), 1'b1);
        repeat (2) @(negedge clk);
        check("p1 valid", 32'(out_valid), 32'd1);
        check("p1 last", 32'(out_last), 32'd1);
        check("p1 index", 32'(out_index), 32'd0);
        check("p1 re", 32'(out_re), 32'(exp_re(10, 0)));
        @(negedge clk);
        check("p1 done", 32'(out_valid), 32'd0);
        check("end ovf_err", 32'(ovf_err), 32'd0);
        check("end addr_err", 32'(addr_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
